// File: rtl/adc_spi_scan.sv
// Multi-channel SPI ADC scan controller.
// Sends one command frame per selected channel. Reads are pipelined: the
// result shifted in during a frame belongs to the channel commanded in the
// frame before it. A NOP flush frame at the end of a single scan collects
// the last result.
module adc_spi_scan #(
    parameter int         DATA_W   = 16,
    parameter int         CMD_W    = 32,
    parameter int         N_CH     = 4,
    parameter int         CH_W     = 2,
    parameter logic [4:0] CMD_OP   = 5'b11001,
    parameter int         SCLK_DIV = 2,
    parameter int         T_ACQ    = 100,
    parameter int         RVS_TO   = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic [N_CH-1:0]   ch_mask,
    input  logic              rvs,
    input  logic              miso,
    output logic              cs,
    output logic              sclk,
    output logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic [CH_W-1:0]   dout_ch,
    output logic              dout_vld,
    output logic              busy,
    output logic              err_to
);

    localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W   = $clog2(CMD_W);
    localparam int CNT_MAX = (T_ACQ > RVS_TO) ? T_ACQ : RVS_TO;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_END = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_END = BIT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] ACQ_END = CNT_W'(T_ACQ - 1);
    localparam logic [CNT_W-1:0] TO_END  = CNT_W'(RVS_TO - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_ACQ  = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    // Lowest set bit of a channel mask (mask assumed non-zero by callers).
    function automatic logic [CH_W-1:0] lowest_set(input logic [N_CH-1:0] m);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = m[i] ? CH_W'(i) : idx;
        end
        return idx;
    endfunction

    // {found, index} of the lowest set bit strictly above cur.
    function automatic logic [CH_W:0] next_above(input logic [N_CH-1:0] m,
                                                 input logic [CH_W-1:0] cur);
        logic [CH_W:0] res;
        res = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            res = (m[i] && (i > int'(cur))) ? {1'b1, CH_W'(i)} : res;
        end
        return res;
    endfunction

    // Command word: opcode and channel in the MSBs, or all zeros for a flush.
    function automatic logic [CMD_W-1:0] make_cmd(input logic flush,
                                                  input logic [CH_W-1:0] ch);
        logic [CMD_W-1:0] c;
        c = '0;
        c[CMD_W-1 -: 5+CH_W] = flush ? {(5+CH_W){1'b0}} : {CMD_OP, ch};
        return c;
    endfunction

    logic [1:0]        r_state;
    logic [DIV_W-1:0]  r_div;
    logic [BIT_W-1:0]  r_bit;
    logic [CNT_W-1:0]  r_cnt;
    logic [CMD_W-1:0]  r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [N_CH-1:0]   r_mask;
    logic [CH_W-1:0]   r_cmd_ch;
    logic              r_cmd_flush;
    logic [CH_W-1:0]   r_prev_ch;
    logic              r_prev_vld;
    logic [CH_W-1:0]   r_vld_ch;
    logic              r_vld_pend;

    logic [CH_W-1:0]   w_start_ch;
    logic [CH_W-1:0]   w_wrap_ch;
    logic [CH_W:0]     w_next;
    logic [CMD_W-1:0]  w_cmd_start;
    logic [CMD_W-1:0]  w_cmd_next;

    // Channel selection and command words for the frame about to start.
    always_comb begin
        w_start_ch  = lowest_set(ch_mask);
        w_wrap_ch   = lowest_set(r_mask);
        w_next      = next_above(r_mask, r_cmd_ch);
        w_cmd_start = make_cmd(1'b0, w_start_ch);
        w_cmd_next  = make_cmd(r_cmd_flush, r_cmd_ch);
    end

    // Scan FSM, SPI bit engine and channel sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_bit       <= '0;
            r_cnt       <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_mask      <= '0;
            r_cmd_ch    <= '0;
            r_cmd_flush <= 1'b0;
            r_prev_ch   <= '0;
            r_prev_vld  <= 1'b0;
            r_vld_ch    <= '0;
            r_vld_pend  <= 1'b0;
            cs          <= 1'b1;
            sclk        <= 1'b0;
            mosi        <= 1'b0;
            busy        <= 1'b0;
            err_to      <= 1'b0;
        end else begin
            r_vld_pend <= 1'b0;
            err_to     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && (|ch_mask)) begin
                        r_mask      <= ch_mask;
                        r_cmd_ch    <= w_start_ch;
                        r_cmd_flush <= 1'b0;
                        r_prev_vld  <= 1'b0;
                        busy        <= 1'b1;
                        cs          <= 1'b0;
                        sclk        <= 1'b0;
                        r_div       <= '0;
                        r_bit       <= '0;
                        r_tx        <= w_cmd_start;
                        mosi        <= w_cmd_start[CMD_W-1];
                        r_state     <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (r_div == DIV_END) begin
                        r_div <= '0;
                        if (!sclk) begin
                            // Rising SCLK edge: capture the result bits only.
                            sclk <= 1'b1;
                            if (int'(r_bit) < DATA_W) begin
                                r_rx <= {r_rx[DATA_W-2:0], miso};
                            end
                        end else begin
                            sclk <= 1'b0;
                            if (r_bit == BIT_END) begin
                                // End of frame: release cs and hand the result on.
                                cs         <= 1'b1;
                                mosi       <= 1'b0;
                                r_cnt      <= '0;
                                r_vld_pend <= r_prev_vld;
                                r_vld_ch   <= r_prev_ch;
                                r_prev_ch  <= r_cmd_ch;
                                r_prev_vld <= ~r_cmd_flush;
                                if (r_cmd_flush) begin
                                    busy    <= 1'b0;
                                    r_state <= S_IDLE;
                                end else begin
                                    r_state <= S_ACQ;
                                    if (w_next[CH_W]) begin
                                        r_cmd_ch <= w_next[CH_W-1:0];
                                    end else if (cont) begin
                                        r_cmd_ch <= w_wrap_ch;
                                    end else begin
                                        r_cmd_flush <= 1'b1;
                                    end
                                end
                            end else begin
                                r_bit <= r_bit + BIT_W'(1);
                                mosi  <= r_tx[CMD_W-2];
                                r_tx  <= {r_tx[CMD_W-2:0], 1'b0};
                            end
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_ACQ: begin
                    if (r_cnt == ACQ_END) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (rvs) begin
                        cs      <= 1'b0;
                        sclk    <= 1'b0;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_tx    <= w_cmd_next;
                        mosi    <= w_cmd_next[CMD_W-1];
                        r_state <= S_XFER;
                    end else if (r_cnt == TO_END) begin
                        err_to  <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Result output register: one-cycle valid strobe, data held until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            dout_ch  <= '0;
            dout_vld <= 1'b0;
        end else begin
            dout_vld <= r_vld_pend;
            if (r_vld_pend) begin
                dout    <= r_rx;
                dout_ch <= r_vld_ch;
            end
        end
    end

endmodule
